sd_blk_rx: RTL and testbench
============================

Name: sd_blk_rx

Overview:
Receives one SD data block from the single-bit DAT0 line and writes it, byte by byte, into the 512 x 8 sector RAM.
- Block format: start bit (0), 512 data bytes MSB-first, CRC16 MSB-first, end bit (1).
- Sits directly upstream of the sector RAM and drives its write port.
- Checks CRC16 and framing, and reports completion and status to the command/control FSM.

Parameters:
- ADDR_BITS, 9, sector RAM address width; block length is 1<<ADDR_BITS bytes.
- DATA_BITS, 8, byte width; fixed at 8.
- TIMEOUT_BITS, 16, width of the start-bit timeout counter.
- TIMEOUT_VAL, 16'hFFFF, number of bit_en strobes allowed in WAIT_START before timeout.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-clk pulse that arms reception; ignored while busy=1.
- bit_en  input  1  one-clk strobe per SD bit period; dat_in is sampled only when bit_en=1.
- dat_in  input  1  SD DAT0 line, already synchronised to clk.
- ram_wr  output  1  sector RAM write enable, active high, one clk per byte.
- ram_addr  output  ADDR_BITS  sector RAM address.
- ram_data  output  DATA_BITS  byte to write.
- busy  output  1  high from the cycle after an accepted start until done or timeout.
- done  output  1  one-clk pulse when the end bit has been sampled.
- crc_ok  output  1  1 when the received CRC matches the computed CRC and the end bit is 1; valid from done, held until the next accepted start.
- timeout  output  1  one-clk pulse when no start bit arrives within TIMEOUT_VAL strobes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, and all outputs, shift register, bit/byte counters, CRC and timeout counter are 0.
- States: IDLE, WAIT_START, DATA, CRC, END_BIT.
  - IDLE: start=1 -> WAIT_START; clear CRC to 0, byte index to 0, timeout counter to 0 and crc_ok to 0.
  - WAIT_START: on bit_en with dat_in=0 -> DATA. On bit_en with dat_in=1, increment the timeout counter. When the counter reaches TIMEOUT_VAL: pulse timeout and go to IDLE.
  - DATA: on each bit_en, shift dat_in into the LSB (MSB-first) and update CRC16-CCITT (poly 0x1021, init 0x0000, non-reflected) with dat_in.
    - On the 8th bit of a byte: on the next clk, ram_wr=1 for exactly 1 clk, ram_data = assembled byte, ram_addr = (byte index + 1) mod 512. The +1 is required because the sector RAM stores at addr-1, so byte k lands at RAM location k.
    - The byte index increments after each write.
    - After byte 511's write is issued -> CRC state.
  - CRC: shift 16 bits on bit_en into a received-CRC register; the CRC engine is frozen. After the 16th bit -> END_BIT.
  - END_BIT: on bit_en, sample the end bit. Next clk: done=1 for 1 clk, crc_ok = (rx_crc == calc_crc) && end bit==1, go to IDLE.
- busy: 1 in WAIT_START, DATA, CRC and END_BIT; 0 in IDLE (including the cycle done is high).
- Latency: last data bit sampled -> ram_wr asserted exactly 1 clk later. End bit sampled -> done exactly 1 clk later.
- Minimum bit_en spacing is 2 clk; the write from one byte always completes before the next byte's first bit.
- ram_wr is 0 in every state except the single write cycle. ram_addr and ram_data hold their last values otherwise.
- Wrap-around: byte index 511 -> ram_addr 0 (9-bit wrap); the index is not used past 511.
- start while busy: ignored, no state change.
- start in the same clk as done: accepted; the block re-arms.
- rst_n asserted mid-block: immediate return to IDLE with outputs cleared. The partial RAM contents are left as is and no done is issued.
- bit_en=0: state, counters and CRC hold.

Test Plan:
1. Reset with rst_n=0 mid-DATA (byte 100) -> all outputs 0 at once; after release, busy=0, no further ram_wr, and no done.
2. start, then 5 idle '1' bits, start bit, 512 bytes of 0xFF, CRC 0x7FA1, end bit 1 ->
   - 512 ram_wr pulses with ram_data=0xFF and ram_addr 1,2,...,511,0;
   - done one pulse with crc_ok=1;
   - busy falls with done.
3. Same as 2 but CRC 0x7FA0 -> done pulses, crc_ok=0, all 512 writes still issued.
4. Incrementing payload (byte k = k mod 256), correct CRC, end bit 0 -> crc_ok=0. Also check RAM readback: location k holds k mod 256 for every k.
5. Set TIMEOUT_VAL=10 and hold dat_in=1 -> timeout pulses on the 10th strobe, busy=0, no ram_wr. A second start pulse while busy is ignored (no state change observed).
6. bit_en every 2 clk (maximum rate) and every 7 clk with random gaps -> each ram_wr appears exactly 1 clk after the 8th bit of its byte, and there are no missed or duplicated writes.

Source files
------------

// File: rtl/sd_blk_rx_if.sv
// Bus between the SD block receiver, its controller and the sector RAM write port.
// The receiver connects through the slave modport; the controller side uses master.
interface sd_blk_rx_if #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned DATA_BITS = 8
);
  logic                 start;
  logic                 bit_en;
  logic                 dat_in;
  logic                 ram_wr;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_BITS-1:0] ram_data;
  logic                 busy;
  logic                 done;
  logic                 crc_ok;
  logic                 timeout;

  modport master (
    output start, bit_en, dat_in,
    input  ram_wr, ram_addr, ram_data, busy, done, crc_ok, timeout
  );

  modport slave (
    input  start, bit_en, dat_in,
    output ram_wr, ram_addr, ram_data, busy, done, crc_ok, timeout
  );
endinterface

// File: rtl/sd_blk_rx.sv
// SD single-bit data block receiver: start bit, 1<<ADDR_BITS bytes MSB-first,
// CRC16 and end bit; each byte is written to the sector RAM as it completes.
module sd_blk_rx #(
  parameter int unsigned              ADDR_BITS    = 9,
  parameter int unsigned              DATA_BITS    = 8,
  parameter int unsigned              TIMEOUT_BITS = 16,
  parameter logic [TIMEOUT_BITS-1:0]  TIMEOUT_VAL  = 16'hFFFF
) (
  input logic         clk,
  input logic         rst_n,
  sd_blk_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END_BIT
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] CRC_LAST = 4'd15;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_BITS-1:0]    r_shift;
  logic [3:0]              r_bitcnt;
  logic [ADDR_BITS-1:0]    r_idx;
  logic [15:0]             r_crc;
  logic [15:0]             r_rx_crc;
  logic [TIMEOUT_BITS-1:0] r_tcnt;
  logic                    r_byte_rdy;
  logic                    r_end_seen;
  logic                    r_end_bit;
  logic                    r_wr;
  logic [ADDR_BITS-1:0]    r_ram_addr;
  logic [DATA_BITS-1:0]    r_ram_data;
  logic                    r_done;
  logic                    r_crc_ok;
  logic                    r_timeout;

  logic                    w_arm;
  logic                    w_shift;
  logic                    w_wr_fire;
  logic                    w_rxcrc_shift;
  logic                    w_end_sample;
  logic                    w_done_fire;
  logic                    w_tmo_cnt;
  logic                    w_tmo_fire;
  logic [TIMEOUT_BITS-1:0] w_tcnt_inc;
  logic                    w_crc_fb;
  logic [15:0]             w_crc_nxt;

  assign w_tcnt_inc = r_tcnt + 1'b1;
  assign w_crc_fb   = r_crc[15] ^ bus.dat_in;
  assign w_crc_nxt  = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Byte and end-bit completions are flagged on the sampling edge and acted
  // on one clk later, giving the fixed one-clk write/done latency.
  always_comb begin
    w_state_nxt   = r_state;
    w_arm         = 1'b0;
    w_shift       = 1'b0;
    w_wr_fire     = 1'b0;
    w_rxcrc_shift = 1'b0;
    w_end_sample  = 1'b0;
    w_done_fire   = 1'b0;
    w_tmo_cnt     = 1'b0;
    w_tmo_fire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_arm       = 1'b1;
          w_state_nxt = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (bus.bit_en) begin
          if (!bus.dat_in) begin
            w_state_nxt = S_DATA;
          end else begin
            w_tmo_cnt = 1'b1;
            if (w_tcnt_inc == TIMEOUT_VAL) begin
              w_tmo_fire  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (r_byte_rdy) begin
          w_wr_fire = 1'b1;
          if (r_idx == '1) w_state_nxt = S_CRC;
        end
        if (bus.bit_en) w_shift = 1'b1;
      end
      S_CRC: begin
        if (bus.bit_en) begin
          w_rxcrc_shift = 1'b1;
          if (r_bitcnt == CRC_LAST) w_state_nxt = S_END_BIT;
        end
      end
      S_END_BIT: begin
        if (r_end_seen) begin
          w_done_fire = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.bit_en) begin
          w_end_sample = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_idx      <= '0;
      r_crc      <= '0;
      r_rx_crc   <= '0;
      r_tcnt     <= '0;
      r_byte_rdy <= 1'b0;
      r_end_seen <= 1'b0;
      r_end_bit  <= 1'b0;
      r_wr       <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_wr      <= w_wr_fire;
      r_done    <= w_done_fire;
      r_timeout <= w_tmo_fire;
      if (w_arm) begin
        r_crc      <= '0;
        r_rx_crc   <= '0;
        r_idx      <= '0;
        r_tcnt     <= '0;
        r_bitcnt   <= '0;
        r_crc_ok   <= 1'b0;
        r_byte_rdy <= 1'b0;
        r_end_seen <= 1'b0;
        r_end_bit  <= 1'b0;
      end
      if (w_tmo_cnt) r_tcnt <= w_tcnt_inc;
      // RAM stores at addr-1, so byte k is presented at k+1 (wrapping).
      if (w_wr_fire) begin
        r_byte_rdy <= 1'b0;
        r_ram_data <= r_shift;
        r_ram_addr <= r_idx + 1'b1;
        r_idx      <= r_idx + 1'b1;
      end
      if (w_shift) begin
        r_shift <= {r_shift[DATA_BITS-2:0], bus.dat_in};
        r_crc   <= w_crc_nxt;
        if (r_bitcnt == BIT_LAST) begin
          r_bitcnt   <= '0;
          r_byte_rdy <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end
      if (w_rxcrc_shift) begin
        r_rx_crc <= {r_rx_crc[14:0], bus.dat_in};
        r_bitcnt <= (r_bitcnt == CRC_LAST) ? '0 : r_bitcnt + 1'b1;
      end
      if (w_end_sample) begin
        r_end_bit  <= bus.dat_in;
        r_end_seen <= 1'b1;
      end
      if (w_done_fire) begin
        r_end_seen <= 1'b0;
        r_crc_ok   <= (r_rx_crc == r_crc) && r_end_bit;
      end
    end
  end

  assign bus.ram_wr   = r_wr;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.crc_ok   = r_crc_ok;
  assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_sd_blk_rx.sv
// Bench for sd_blk_rx: table of whole-block scenarios plus hand sequences for
// mid-block reset, re-arm on done and start-bit timeout, checked at negedge.
module tb_sd_blk_rx;
  localparam int unsigned AB  = 9;
  localparam int unsigned NB  = 512;
  localparam int unsigned TMO = 10;

  localparam int unsigned PAT_FF   = 0;
  localparam int unsigned PAT_INC  = 1;
  localparam int unsigned PAT_RAND = 2;

  typedef struct {
    int unsigned pat;
    logic        crc_explicit;
    logic [15:0] crc_val;
    logic        end_bit;
    int unsigned idle;
    int unsigned gmin;
    int unsigned gmax;
    logic        exp_ok;
    logic        chk_ram;
    logic        b2b;
  } blk_vec_t;

  typedef struct {
    logic [AB-1:0] addr;
    logic [7:0]    data;
    int unsigned   cyc;
  } wr_t;

  typedef struct {
    int unsigned cyc;
    logic        ok;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned ncyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned n_wr_seen = 0;

  logic [7:0]  payload [NB];
  logic [7:0]  ram_m [NB];
  wr_t         exp_wr [$];
  done_t       exp_done [$];
  int unsigned exp_tmo [$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  sd_blk_rx_if #(.ADDR_BITS(AB), .DATA_BITS(8)) bus ();

  sd_blk_rx #(
    .ADDR_BITS   (AB),
    .DATA_BITS   (8),
    .TIMEOUT_BITS(16),
    .TIMEOUT_VAL (16'(TMO))
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // CRC16-CCITT, init 0, byte-at-a-time over the whole payload
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'h0000;
    for (int unsigned k = 0; k < NB; k++) begin
      c = c ^ {payload[k], 8'h00};
      for (int unsigned j = 0; j < 8; j++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic void fill_payload(input int unsigned pat);
    for (int unsigned k = 0; k < NB; k++) begin
      case (pat)
        PAT_FF:  payload[k] = 8'hFF;
        PAT_INC: payload[k] = 8'(k);
        default: payload[k] = 8'($urandom);
      endcase
    end
  endfunction

  // Called at a negedge; returns at the negedge `gap` clocks later.
  task automatic send_bit(input logic b, input int unsigned gap);
    bus.bit_en = 1'b1;
    bus.dat_in = b;
    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.dat_in = 1'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_byte(input int unsigned k, input int unsigned gmin, input int unsigned gmax);
    for (int b = 7; b >= 0; b--) begin
      if (b == 0) exp_wr.push_back('{addr: AB'(k + 1), data: payload[k], cyc: ncyc + 2});
      send_bit(payload[k][b], $urandom_range(gmax, gmin));
    end
  endtask

  // Returns at the negedge on which done is expected.
  task automatic send_block(input blk_vec_t v);
    logic [15:0] crc;
    int unsigned base;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("crc_ok_cleared_on_start", bus.crc_ok, 0);
    check("prev_writes_drained", exp_wr.size(), 0);
    check("prev_done_seen", exp_done.size(), 0);
    base = n_wr_seen;
    crc = v.crc_explicit ? v.crc_val : crc_model();
    repeat (v.idle) send_bit(1'b1, $urandom_range(v.gmax, v.gmin));
    send_bit(1'b0, $urandom_range(v.gmax, v.gmin));
    for (int unsigned k = 0; k < NB; k++) send_byte(k, v.gmin, v.gmax);
    for (int b = 15; b >= 0; b--) send_bit(crc[b], $urandom_range(v.gmax, v.gmin));
    exp_done.push_back('{cyc: ncyc + 2, ok: v.exp_ok});
    send_bit(v.end_bit, 2);
    check("block_write_count", n_wr_seen - base, NB);
  endtask

  always @(negedge clk) begin : mon
    wr_t         e;
    done_t       d;
    logic        want;
    int unsigned loc;
    want = 1'b0;
    if (exp_wr.size() != 0) want = (exp_wr[0].cyc == ncyc);
    check("ram_wr_timing", bus.ram_wr, want);
    if (want) begin
      e = exp_wr.pop_front();
      if (bus.ram_wr) begin
        n_wr_seen++;
        check("ram_addr", bus.ram_addr, e.addr);
        check("ram_data", bus.ram_data, e.data);
        loc = (32'(bus.ram_addr) + NB - 1) % NB;
        ram_m[loc] = bus.ram_data;
      end
    end
    want = 1'b0;
    if (exp_done.size() != 0) want = (exp_done[0].cyc == ncyc);
    check("done_timing", bus.done, want);
    if (want) begin
      d = exp_done.pop_front();
      if (bus.done) begin
        check("crc_ok", bus.crc_ok, d.ok);
        check("busy_low_with_done", bus.busy, 0);
      end
    end
    want = 1'b0;
    if (exp_tmo.size() != 0) want = (exp_tmo[0] == ncyc);
    check("timeout_timing", bus.timeout, want);
    if (want) void'(exp_tmo.pop_front());
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    blk_vec_t vecs [5];
    int unsigned bad;
    int unsigned first_bad;
    vecs[0] = '{pat: PAT_FF,   crc_explicit: 1'b1, crc_val: 16'h7FA1, end_bit: 1'b1, idle: 5,
                gmin: 2, gmax: 2, exp_ok: 1'b1, chk_ram: 1'b0, b2b: 1'b0};
    vecs[1] = '{pat: PAT_FF,   crc_explicit: 1'b1, crc_val: 16'h7FA0, end_bit: 1'b1, idle: 3,
                gmin: 2, gmax: 3, exp_ok: 1'b0, chk_ram: 1'b0, b2b: 1'b0};
    vecs[2] = '{pat: PAT_INC,  crc_explicit: 1'b0, crc_val: 16'h0000, end_bit: 1'b0, idle: 0,
                gmin: 2, gmax: 2, exp_ok: 1'b0, chk_ram: 1'b1, b2b: 1'b0};
    vecs[3] = '{pat: PAT_RAND, crc_explicit: 1'b0, crc_val: 16'h0000, end_bit: 1'b1, idle: 2,
                gmin: 2, gmax: 2, exp_ok: 1'b1, chk_ram: 1'b0, b2b: 1'b0};
    vecs[4] = '{pat: PAT_RAND, crc_explicit: 1'b0, crc_val: 16'h0000, end_bit: 1'b1, idle: 1,
                gmin: 2, gmax: 7, exp_ok: 1'b1, chk_ram: 1'b0, b2b: 1'b1};

    bus.start  = 1'b0;
    bus.bit_en = 1'b0;
    bus.dat_in = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ram_wr", bus.ram_wr, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_data", bus.ram_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_crc_ok", bus.crc_ok, 0);
    check("rst_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of byte 100
    fill_payload(PAT_RAND);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("midrst_busy_armed", bus.busy, 1);
    send_bit(1'b0, 2);
    for (int unsigned k = 0; k < 100; k++) send_byte(k, 2, 2);
    for (int b = 7; b >= 5; b--) send_bit(payload[100][b], 2);
    check("midrst_addr_held", bus.ram_addr, 100);
    check("midrst_data_held", bus.ram_data, payload[99]);
    check("midrst_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_ram_wr", bus.ram_wr, 0);
    check("midrst_ram_addr", bus.ram_addr, 0);
    check("midrst_ram_data", bus.ram_data, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_crc_ok", bus.crc_ok, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) send_bit(1'($urandom), 2);
    check("postrst_busy", bus.busy, 0);
    check("postrst_no_writes_pending", exp_wr.size(), 0);

    for (int unsigned i = 0; i < 5; i++) begin
      fill_payload(vecs[i].pat);
      if (vecs[i].chk_ram)
        for (int unsigned k = 0; k < NB; k++) ram_m[k] = ~8'(k);
      if (!vecs[i].b2b) repeat (3) @(negedge clk);
      send_block(vecs[i]);
      if (vecs[i].chk_ram) begin
        bad = 0;
        first_bad = 0;
        for (int unsigned k = 0; k < NB; k++)
          if (ram_m[k] !== 8'(k)) begin
            if (bad == 0) first_bad = k;
            bad++;
          end
        check("ram_readback_bad_locations", bad, 0);
        if (bad != 0) $display("  first bad RAM location %0d", first_bad);
      end
    end

    // Re-arm in the done cycle, then time out waiting for a start bit
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rearm_on_done_busy", bus.busy, 1);
    check("rearm_crc_ok_cleared", bus.crc_ok, 0);
    check("last_block_writes_drained", exp_wr.size(), 0);
    check("last_block_done_seen", exp_done.size(), 0);
    for (int unsigned s = 1; s <= TMO; s++) begin
      if (s == TMO) exp_tmo.push_back(ncyc + 1);
      if (s == 5) bus.start = 1'b1;
      bus.bit_en = 1'b1;
      bus.dat_in = 1'b1;
      @(negedge clk);
      bus.bit_en = 1'b0;
      bus.start  = 1'b0;
      if (s < TMO) begin
        check("tmo_busy_waiting", bus.busy, 1);
      end else begin
        check("tmo_pulse", bus.timeout, 1);
        check("tmo_busy_low", bus.busy, 0);
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("tmo_single_pulse", bus.timeout, 0);
    check("tmo_busy_idle", bus.busy, 0);
    check("tmo_event_seen", exp_tmo.size(), 0);
    check("final_writes_drained", exp_wr.size(), 0);
    check("final_done_drained", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
